alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 8-bit combinational ALU. It keeps the same opcode map and flag semantics, widened to WIDTH bits. Operands enter through a valid/ready port, and results leave through a registered valid/ready port. MUL, DIV and MOD run as iterative multi-cycle operations and also return a high half. It sits between the register-file read stage and the write-back stage of the microprocessor datapath.

## Interface
- WIDTH, 8: operand/result width, ≥4, power of two.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept; high only in IDLE.
- alu_sel  in  8  opcode.
- operand1  in  WIDTH  first source.
- operand2  in  WIDTH  second source.
- out_valid  out  1  result registers hold a result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  low result.
- result_hi  out  WIDTH  MUL high product, DIV/MOD remainder, else 0.
- flags  out  7  {illegal, divzero, parity, overflow, negative, carry, zero} as bits [6:0].

## Operation
- Opcodes, with one-bit shifts/rotates and operand2 ignored where unused:
  - 0x01 ADD, 0x02 SUB, 0x03 MUL, 0x04 DIV, 0x05 INC, 0x06 DEC, 0x07 MOD.
  - 0x08 SHL, 0x09 SHR, 0x0A AND, 0x0B NAND, 0x0D NOR, 0x0F OR.
  - 0x10 XNOR, 0x11 XOR, 0x12 ROL, 0x13 ROR.
  - Any other value is illegal.
- States:
  - IDLE: accept when in_valid.
  - BUSY: iterate MUL/DIV/MOD.
  - DONE: hold outputs until out_ready.
- Transitions:
  - IDLE→DONE: single-cycle op accepted.
  - IDLE→BUSY: MUL, DIV or MOD with operand2≠0 accepted.
  - BUSY→DONE: after WIDTH iterations.
  - DONE→IDLE: out_valid & out_ready.
- Operands and opcode are captured at acceptance; later input changes do not affect the operation.
- Arithmetic modulo 2^WIDTH:
  - MUL: unsigned shift-add, one bit per cycle, full 2·WIDTH product → {result_hi, result}.
  - DIV/MOD: unsigned restoring division, one bit per cycle.
    - DIV: result = quotient, result_hi = remainder.
    - MOD: result = remainder, result_hi = quotient.
  - Divide/modulo by zero: result = all ones, result_hi = operand1, divzero=1, zero=0; completes in one cycle (no BUSY).
- Flags, registered together with the result:
  - zero: result==0.
  - negative: result[WIDTH-1].
  - parity: XOR-reduce of result is 0 (even parity).
  - carry:
    - ADD: carry-out. SUB: borrow (operand1<operand2).
    - INC: operand1 all ones. DEC: operand1==0.
    - SHL/ROL: old MSB. SHR/ROR: old LSB.
    - MUL: result_hi≠0.
    - All other ops: 0.
  - overflow: two's-complement overflow for ADD/SUB/INC/DEC; 0 otherwise.
  - illegal: opcode not in the map; result=0, result_hi=0, zero=1, other flags 0; single-cycle.
- Reset values (rst_n low, immediate): state IDLE, out_valid 0, result 0, result_hi 0, flags 0. in_ready is 1 once rst_n is high. Reset mid-BUSY or mid-DONE discards the operation; no result is ever presented for it.

## Timing
- Acceptance: rising edge with in_valid & in_ready.
- Single-cycle ops, DIV/MOD by zero, illegal opcodes: out_valid high from acceptance edge + 1 cycle.
- MUL/DIV/MOD (operand2≠0): out_valid high exactly WIDTH+1 cycles after the acceptance edge. in_ready low throughout.
- While out_valid & !out_ready: result, result_hi, flags and out_valid are held stable.
- Output transfer edge: state returns to IDLE, out_valid drops next cycle, in_ready rises next cycle.
- No same-cycle accept and release. Throughput is at most one op per 2 cycles (single-cycle ops) or WIDTH+2 cycles (iterative ops).
- in_valid during BUSY/DONE is ignored. The producer holds its request until in_ready.

## Test plan
- WIDTH=8, ADD 255+1, out_ready=1 → result 0, flags zero=1, carry=1; out_valid 1 cycle after accept; ADD 10+15 → 25, zero=0.
- WIDTH=8, MUL 27×4 → result 108, result_hi 0, out_valid at accept+9; MUL 200×200 → result 0x40, result_hi 0x9C, carry=1.
- WIDTH=8:
  - DIV 30/4 → result 7, result_hi 2, at accept+9.
  - MOD 30/4 → result 2, result_hi 7.
  - DIV 8/0 → result 255, result_hi 8, divzero=1 at accept+1.
- WIDTH=8:
  - ROL 0xAA → 0x55, carry=1; ROR 0x01 → 0x80, carry=1.
  - Opcode 0x0C → result 0, illegal=1, zero=1.
  - SUB 1−2 → 0xFF, carry=1, negative=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready 0, new in_valid ignored. Then pulse out_ready → in_ready high next cycle.
- WIDTH=16: assert rst_n=0 during a MUL at iteration 5 → out_valid/result/flags 0 immediately. After release, ADD 0xFFFF+1 → result 0, carry=1, zero=1, with no stale MUL result ever presented.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq - handshaked, parameterised ALU placed between register-file read
// and write-back. Single-cycle ops finish at the acceptance edge. MUL, DIV
// and MOD with a non-zero operand2 are iterated one bit per clock.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   alu_sel               8-bit opcode
//   operand1, operand2    WIDTH-bit sources, captured at acceptance
//   out_valid / out_ready result handshake; outputs are held while stalled
//   result, result_hi     low result; MUL high half / DIV-MOD companion
//   flags                 {illegal, divzero, parity, overflow, negative, carry, zero}
`timescale 1ns/1ps
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       alu_sel,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [6:0]       flags
);
    localparam logic [7:0] OP_ADD  = 8'h01, OP_SUB  = 8'h02, OP_MUL  = 8'h03;
    localparam logic [7:0] OP_DIV  = 8'h04, OP_INC  = 8'h05, OP_DEC  = 8'h06;
    localparam logic [7:0] OP_MOD  = 8'h07, OP_SHL  = 8'h08, OP_SHR  = 8'h09;
    localparam logic [7:0] OP_AND  = 8'h0A, OP_NAND = 8'h0B, OP_NOR  = 8'h0D;
    localparam logic [7:0] OP_OR   = 8'h0F, OP_XNOR = 8'h10, OP_XOR  = 8'h11;
    localparam logic [7:0] OP_ROL  = 8'h12, OP_ROR  = 8'h13;
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state, w_nextState;
    logic [7:0]         r_op;
    logic [WIDTH-1:0]   r_operand;      // multiplicand for MUL, divisor for DIV/MOD
    logic [2*WIDTH-1:0] r_acc;          // {high half / remainder, multiplier / dividend}
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_result, r_resultHi;
    logic [6:0]         r_flags;

    logic               w_accept, w_iterative, w_isMul;
    logic [WIDTH:0]     w_sum;
    logic               w_carry, w_ovf, w_illegal, w_divzero;
    logic [WIDTH-1:0]   w_scRes, w_scHi;
    logic [6:0]         w_scFlags;
    logic [WIDTH:0]     w_mulSum, w_remShift, w_trial;
    logic [2*WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0]   w_itRes, w_itHi;
    logic [6:0]         w_itFlags;

    assign w_accept    = in_valid && in_ready;
    assign w_isMul     = (alu_sel == OP_MUL);
    // Division by zero and MUL by zero are resolved in the single-cycle path.
    assign w_iterative = (w_isMul || alu_sel == OP_DIV || alu_sel == OP_MOD) && (operand2 != '0);

    // Results for every op that completes at the acceptance edge, including
    // MUL by zero, DIV/MOD by zero and illegal opcodes.
    always_comb begin
        w_sum     = '0;
        w_scRes   = '0;
        w_scHi    = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_illegal = 1'b0;
        w_divzero = 1'b0;
        case (alu_sel)
            OP_ADD: begin
                w_sum   = {1'b0, operand1} + {1'b0, operand2};
                w_scRes = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (operand1[MSB] == operand2[MSB]) && (w_scRes[MSB] != operand1[MSB]);
            end
            OP_SUB: begin
                w_sum   = {1'b0, operand1} - {1'b0, operand2};
                w_scRes = w_sum[MSB:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (operand1[MSB] != operand2[MSB]) && (w_scRes[MSB] != operand1[MSB]);
            end
            OP_MUL: w_scRes = '0;
            OP_DIV, OP_MOD: begin
                w_scRes   = '1;
                w_scHi    = operand1;
                w_divzero = 1'b1;
            end
            OP_INC: begin
                w_scRes = operand1 + 1'b1;
                w_carry = &operand1;
                w_ovf   = !operand1[MSB] && w_scRes[MSB];
            end
            OP_DEC: begin
                w_scRes = operand1 - 1'b1;
                w_carry = (operand1 == '0);
                w_ovf   = operand1[MSB] && !w_scRes[MSB];
            end
            OP_SHL: begin
                w_scRes = {operand1[MSB-1:0], 1'b0};
                w_carry = operand1[MSB];
            end
            OP_SHR: begin
                w_scRes = {1'b0, operand1[MSB:1]};
                w_carry = operand1[0];
            end
            OP_AND:  w_scRes = operand1 & operand2;
            OP_NAND: w_scRes = ~(operand1 & operand2);
            OP_NOR:  w_scRes = ~(operand1 | operand2);
            OP_OR:   w_scRes = operand1 | operand2;
            OP_XNOR: w_scRes = ~(operand1 ^ operand2);
            OP_XOR:  w_scRes = operand1 ^ operand2;
            OP_ROL: begin
                w_scRes = {operand1[MSB-1:0], operand1[MSB]};
                w_carry = operand1[MSB];
            end
            OP_ROR: begin
                w_scRes = {operand1[0], operand1[MSB:1]};
                w_carry = operand1[0];
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal)
            w_scFlags = 7'b100_0001;
        else
            w_scFlags = {1'b0, w_divzero, ~^w_scRes, w_ovf, w_scRes[MSB], w_carry, (w_scRes == '0)};
    end

    // One iteration step: shift-add multiply (shift right) or restoring
    // division (shift left, trial subtract, keep if non-negative).
    assign w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_operand} : '0);
    assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_remShift - {1'b0, r_operand};

    always_comb begin
        if (r_op == OP_MUL)
            w_accNext = {w_mulSum, r_acc[WIDTH-1:1]};
        else if (w_trial[WIDTH])
            w_accNext = {w_remShift[MSB:0], r_acc[WIDTH-2:0], 1'b0};
        else
            w_accNext = {w_trial[MSB:0], r_acc[WIDTH-2:0], 1'b1};
    end

    // The last iteration's outcome is registered directly, so the final
    // step and the transfer to DONE share one edge. MOD swaps the halves.
    always_comb begin
        if (r_op == OP_MOD) begin
            w_itRes = w_accNext[2*WIDTH-1:WIDTH];
            w_itHi  = w_accNext[MSB:0];
        end else begin
            w_itRes = w_accNext[MSB:0];
            w_itHi  = w_accNext[2*WIDTH-1:WIDTH];
        end
        w_itFlags = {2'b00, ~^w_itRes, 1'b0, w_itRes[MSB],
                     (r_op == OP_MUL) && (w_itHi != '0), (w_itRes == '0)};
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_nextState = w_iterative ? S_BUSY : S_DONE;
            S_BUSY: if (r_cnt == LAST) w_nextState = S_DONE;
            S_DONE: if (out_ready) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_operand  <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_resultHi <= '0;
            r_flags    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= alu_sel;
                        r_operand <= w_isMul ? operand1 : operand2;
                        r_acc     <= {{WIDTH{1'b0}}, (w_isMul ? operand2 : operand1)};
                        r_cnt     <= '0;
                        if (!w_iterative) begin
                            r_result   <= w_scRes;
                            r_resultHi <= w_scHi;
                            r_flags    <= w_scFlags;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc <= w_accNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_result   <= w_itRes;
                        r_resultHi <= w_itHi;
                        r_flags    <= w_itFlags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign result_hi = r_resultHi;
    assign flags     = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq - directed checks of alu_seq at WIDTH=8 and WIDTH=16.
`timescale 1ns/1ps
module tb_alu_seq;
    localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04, OP_MOD = 8'h07, OP_XOR = 8'h11;
    localparam logic [7:0] OP_ROL = 8'h12, OP_ROR = 8'h13, OP_BAD = 8'h0C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b0;
    logic        in_ready8, out_valid8;
    logic [7:0]  alu_sel8 = '0, op1_8 = '0, op2_8 = '0, result8, result_hi8;
    logic [6:0]  flags8;

    logic        rst_n16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b0;
    logic        in_ready16, out_valid16;
    logic [7:0]  alu_sel16 = '0;
    logic [15:0] op1_16 = '0, op2_16 = '0, result16, result_hi16;
    logic [6:0]  flags16;

    int compareCount = 0;
    int errorCount   = 0;
    logic sawStale;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_sel(alu_sel8), .operand1(op1_8), .operand2(op2_8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .result_hi(result_hi8), .flags(flags8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n16), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_sel(alu_sel16), .operand1(op1_16), .operand2(op2_16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .result_hi(result_hi16), .flags(flags16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one op to the 8-bit unit, wait (bounded) for acceptance, then
    // scramble the inputs so a design that fails to capture them is exposed.
    task automatic applyStimulus(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
        int waitCycles = 0;
        @(negedge clk);
        alu_sel8 = sel; op1_8 = a; op2_8 = b; in_valid8 = 1'b1;
        while (!in_ready8 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("accept_ready", {31'b0, in_ready8}, 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0; alu_sel8 = OP_BAD; op1_8 = ~a; op2_8 = ~b;
    endtask

    // Called #1 after the acceptance edge; reports latency as 1 + edges waited.
    task automatic waitResult(input string tag, input int expCycles);
        int n = 0;
        while (!out_valid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, "_latency"}, n + 1, expCycles);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expRes, input logic [7:0] expHi,
                               input logic [6:0] expFlags, input int expCycles);
        waitResult(tag, expCycles);
        checkOutput({tag, "_result"}, {24'b0, result8}, {24'b0, expRes});
        checkOutput({tag, "_result_hi"}, {24'b0, result_hi8}, {24'b0, expHi});
        checkOutput({tag, "_flags"}, {25'b0, flags8}, {25'b0, expFlags});
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'b0, out_valid8}, 32'd0);
    endtask

    initial begin
        #3;
        checkOutput("rst8_valid", {31'b0, out_valid8}, 32'd0);
        checkOutput("rst8_result", {24'b0, result8}, 32'd0);
        checkOutput("rst8_result_hi", {24'b0, result_hi8}, 32'd0);
        checkOutput("rst8_flags", {25'b0, flags8}, 32'd0);
        checkOutput("rst16_valid", {31'b0, out_valid16}, 32'd0);
        @(negedge clk);
        rst_n8 = 1'b1; rst_n16 = 1'b1;
        #1;
        checkOutput("rst8_in_ready", {31'b0, in_ready8}, 32'd1);

        // flags: {illegal, divzero, parity, overflow, negative, carry, zero}
        applyStimulus(OP_ADD, 8'hFF, 8'h01); checkResult("add_wrap", 8'h00, 8'h00, 7'h13, 1);
        applyStimulus(OP_ADD, 8'h0A, 8'h0F); checkResult("add_small", 8'h19, 8'h00, 7'h00, 1);
        applyStimulus(OP_MUL, 8'h1B, 8'h04); checkResult("mul_27x4", 8'h6C, 8'h00, 7'h10, 9);
        applyStimulus(OP_MUL, 8'hC8, 8'hC8); checkResult("mul_200x200", 8'h40, 8'h9C, 7'h02, 9);
        applyStimulus(OP_DIV, 8'h1E, 8'h04); checkResult("div_30_4", 8'h07, 8'h02, 7'h00, 9);
        applyStimulus(OP_MOD, 8'h1E, 8'h04); checkResult("mod_30_4", 8'h02, 8'h07, 7'h00, 9);
        applyStimulus(OP_DIV, 8'h08, 8'h00); checkResult("div_by_zero", 8'hFF, 8'h08, 7'h34, 1);
        applyStimulus(OP_ROL, 8'hAA, 8'h33); checkResult("rol_aa", 8'h55, 8'h00, 7'h12, 1);
        applyStimulus(OP_ROR, 8'h01, 8'h33); checkResult("ror_01", 8'h80, 8'h00, 7'h06, 1);
        applyStimulus(OP_BAD, 8'h5A, 8'hA5); checkResult("illegal_0c", 8'h00, 8'h00, 7'h41, 1);
        applyStimulus(OP_SUB, 8'h01, 8'h02); checkResult("sub_borrow", 8'hFF, 8'h00, 7'h16, 1);

        // Backpressure: result held while a new request waits for in_ready.
        applyStimulus(OP_XOR, 8'hF0, 8'h3C);
        waitResult("bp_xor", 1);
        alu_sel8 = OP_ADD; op1_8 = 8'h01; op2_8 = 8'h01; in_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_result", {24'b0, result8}, 32'hCC);
            checkOutput("bp_hold_flags", {25'b0, flags8}, 32'h14);
            checkOutput("bp_hold_valid", {31'b0, out_valid8}, 32'd1);
            checkOutput("bp_hold_in_ready", {31'b0, in_ready8}, 32'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        checkOutput("bp_release_valid", {31'b0, out_valid8}, 32'd0);
        checkOutput("bp_release_in_ready", {31'b0, in_ready8}, 32'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checkOutput("bp_next_valid", {31'b0, out_valid8}, 32'd1);
        checkOutput("bp_next_result", {24'b0, result8}, 32'h02);
        checkOutput("bp_next_flags", {25'b0, flags8}, 32'h00);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;

        // WIDTH=16: leave a visible result, then reset in the middle of a MUL.
        @(negedge clk);
        alu_sel16 = OP_ADD; op1_16 = 16'h7FFF; op2_16 = 16'h0001; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checkOutput("w16_pre_valid", {31'b0, out_valid16}, 32'd1);
        checkOutput("w16_pre_result", {16'b0, result16}, 32'h8000);
        checkOutput("w16_pre_flags", {25'b0, flags16}, 32'h0C);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;

        @(negedge clk);
        alu_sel16 = OP_MUL; op1_16 = 16'h1234; op2_16 = 16'h0100; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("w16_busy_in_ready", {31'b0, in_ready16}, 32'd0);
        checkOutput("w16_busy_valid", {31'b0, out_valid16}, 32'd0);
        #1;
        rst_n16 = 1'b0;
        #1;
        checkOutput("w16_rst_valid", {31'b0, out_valid16}, 32'd0);
        checkOutput("w16_rst_result", {16'b0, result16}, 32'd0);
        checkOutput("w16_rst_result_hi", {16'b0, result_hi16}, 32'd0);
        checkOutput("w16_rst_flags", {25'b0, flags16}, 32'd0);
        @(negedge clk);
        rst_n16 = 1'b1;
        sawStale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid16) sawStale = 1'b1;
        end
        checkOutput("w16_no_stale_mul", {31'b0, sawStale}, 32'd0);
        checkOutput("w16_post_in_ready", {31'b0, in_ready16}, 32'd1);

        @(negedge clk);
        alu_sel16 = OP_ADD; op1_16 = 16'hFFFF; op2_16 = 16'h0001; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checkOutput("w16_add_valid", {31'b0, out_valid16}, 32'd1);
        checkOutput("w16_add_result", {16'b0, result16}, 32'h0000);
        checkOutput("w16_add_result_hi", {16'b0, result_hi16}, 32'h0000);
        checkOutput("w16_add_flags", {25'b0, flags16}, 32'h13);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end
endmodule
